// File: rtl/mem_responder_pkg.sv
// Shared types and limits for the memory responder.
package mem_responder_pkg;

   // Largest supported number of read wait states.
   localparam int MAX_RD_LAT = 3;

   // Responder sequencing states.
   typedef enum logic [1:0] {
      M_IDLE   = 2'd0,
      M_RWAIT  = 2'd1,
      M_RDONE  = 2'd2,
      M_WFLUSH = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are never reset so they survive a responder reset.
module mem_responder_mem_array #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] waddr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic [AWIDTH-1:0] raddr_i,
   output logic [DWIDTH-1:0] rdata_o
);

   logic [DWIDTH-1:0] mem_q [2**AWIDTH];

   // Synchronous write port.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for level-style read/write strobes: edge detection,
// wait-stated reads, immediate idle writes, a one-entry write buffer for
// writes arriving mid-read, and a sticky protocol-error flag.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [AWIDTH-1:0] addr,
   input  logic [DWIDTH-1:0] data_in,
   output logic [DWIDTH-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              err
);

   if (RD_LAT < 0 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
      $error("mem_responder: RD_LAT must be within 0..%0d", MAX_RD_LAT);
   end

   localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

   mem_state_t        state_q, state_d;
   logic              mem_rd_q, mem_wr_q;
   logic              rd_rise, wr_rise;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
   logic              pend_v_q, pend_v_d;
   logic [AWIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [DWIDTH-1:0] pend_data_q, pend_data_d;
   logic              err_q, err_d;
   logic [DWIDTH-1:0] data_out_q;
   logic              rd_valid_q;
   logic              we;
   logic [AWIDTH-1:0] waddr;
   logic [DWIDTH-1:0] wdata;
   logic [DWIDTH-1:0] rdata;

   assign rd_rise = mem_rd & ~mem_rd_q;
   assign wr_rise = mem_wr & ~mem_wr_q;

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= M_IDLE;
         mem_rd_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         wait_cnt_q <= '0;
         pend_v_q   <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_rd_q   <= mem_rd;
         mem_wr_q   <= mem_wr;
         wait_cnt_q <= wait_cnt_d;
         pend_v_q   <= pend_v_d;
         err_q      <= err_d;
         rd_valid_q <= (state_q == M_RDONE);
         if (state_q == M_RDONE) data_out_q <= rdata;
      end
   end

   // Address and buffered-write payload registers; qualified by state, not reset.
   always_ff @(posedge clk) begin
      rd_addr_q   <= rd_addr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
   end

   // Next-state logic: strobe events, wait countdown and write-buffer bookkeeping.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      rd_addr_d   = rd_addr_q;
      pend_v_d    = pend_v_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      err_d       = err_q;

      // Strobes arriving while a transaction is in flight.
      if (state_q != M_IDLE) begin
         if (rd_rise) err_d = 1'b1;
         if (wr_rise) begin
            if (pend_v_q) begin
               err_d = 1'b1;
            end else begin
               pend_v_d    = 1'b1;
               pend_addr_d = addr;
               pend_data_d = data_in;
            end
         end
      end

      case (state_q)
         M_IDLE: begin
            if (rd_rise && wr_rise) begin
               err_d = 1'b1;
            end else if (rd_rise) begin
               rd_addr_d  = addr;
               wait_cnt_d = RD_LAT_C;
               state_d    = M_RWAIT;
            end
         end
         M_RWAIT: begin
            if (wait_cnt_q == 2'd0) state_d = M_RDONE;
            else                    wait_cnt_d = wait_cnt_q - 2'd1;
         end
         // A write captured on this very edge must still be flushed.
         M_RDONE:  state_d = pend_v_d ? M_WFLUSH : M_IDLE;
         M_WFLUSH: begin
            pend_v_d = 1'b0;
            state_d  = M_IDLE;
         end
         default:  state_d = M_IDLE;
      endcase
   end

   // Output logic: write-port mux between the direct path and the buffer.
   always_comb begin
      we    = 1'b0;
      waddr = addr;
      wdata = data_in;
      if (state_q == M_WFLUSH) begin
         we    = 1'b1;
         waddr = pend_addr_q;
         wdata = pend_data_q;
      end else if (state_q == M_IDLE && wr_rise && !rd_rise) begin
         we = 1'b1;
      end
   end

   mem_responder_mem_array #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (we & ~rst),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (rd_addr_q),
      .rdata_o (rdata)
   );

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign err      = err_q;
   assign busy     = (state_q != M_IDLE) | pend_v_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (RD_LAT = 1, 0, 3) checked against
// a word-array model with transaction-level timing expectations.
module tb_mem_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mrd [3];
   logic       mwr [3];
   logic [4:0] addr = '0;
   logic [7:0] din  = '0;
   logic [7:0] dout [3];
   logic       rdv  [3];
   logic       bsy  [3];
   logic       er   [3];

   logic [7:0] model [3][32];
   bit         exp_err [3];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   mem_responder #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .mem_rd(mrd[0]), .mem_wr(mwr[0]), .addr(addr), .data_in(din),
      .data_out(dout[0]), .rd_valid(rdv[0]), .busy(bsy[0]), .err(er[0]));
   mem_responder #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .mem_rd(mrd[1]), .mem_wr(mwr[1]), .addr(addr), .data_in(din),
      .data_out(dout[1]), .rd_valid(rdv[1]), .busy(bsy[1]), .err(er[1]));
   mem_responder #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .mem_rd(mrd[2]), .mem_wr(mwr[2]), .addr(addr), .data_in(din),
      .data_out(dout[2]), .rd_valid(rdv[2]), .busy(bsy[2]), .err(er[2]));

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 0 : 3;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin mrd[i] = 1'b0; mwr[i] = 1'b0; exp_err[i] = 1'b0; end
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic do_write(input int d, input logic [4:0] a, input logic [7:0] v);
      addr = a; din = v; mwr[d] = 1'b1;
      tick();
      mwr[d] = 1'b0;
      n_checks++;
      if (bsy[d] !== 1'b0) begin n_fail++; $display("FAIL write_busy d=%0d got=%b exp=0", d, bsy[d]); end
      tick();
      model[d][a] = v;
   endtask

   // Read with a strobe held for 'hold' edges; optionally a write rises one edge
   // after the read so it lands in the write buffer.
   task automatic do_read(input int d, input logic [4:0] a, input int hold,
                          input bit wen, input logic [4:0] wa, input logic [7:0] wv);
      int lat, total;
      logic [7:0] exp;
      lat   = 2 + lat_of(d);
      exp   = model[d][a];
      total = (hold > lat + 1) ? hold : lat + 1;
      addr = a; mrd[d] = 1'b1;
      tick();
      for (int j = 0; j <= total; j++) begin
         n_checks++;
         if (rdv[d] !== 1'(j == lat)) begin
            n_fail++; $display("FAIL rd_valid d=%0d j=%0d got=%b exp=%b", d, j, rdv[d], (j == lat));
         end
         if (j < lat) begin
            n_checks++;
            if (bsy[d] !== 1'b1) begin n_fail++; $display("FAIL rd_busy d=%0d j=%0d got=%b exp=1", d, j, bsy[d]); end
         end
         if (j >= lat) begin
            n_checks++;
            if (dout[d] !== exp) begin n_fail++; $display("FAIL rd_data d=%0d j=%0d a=%0d got=%h exp=%h", d, j, a, dout[d], exp); end
         end
         if (j == lat && wen) begin
            n_checks++;
            if (bsy[d] !== 1'b1) begin n_fail++; $display("FAIL flush_busy d=%0d got=%b exp=1", d, bsy[d]); end
         end
         mrd[d] = (j + 1 < hold);
         addr = 5'($urandom); din = 8'($urandom);
         if (wen && j == 0) begin mwr[d] = 1'b1; addr = wa; din = wv; end
         else mwr[d] = 1'b0;
         tick();
      end
      n_checks++;
      if (bsy[d] !== 1'b0) begin n_fail++; $display("FAIL end_busy d=%0d got=%b exp=0", d, bsy[d]); end
      n_checks++;
      if (er[d] !== exp_err[d]) begin n_fail++; $display("FAIL rd_err d=%0d got=%b exp=%b", d, er[d], exp_err[d]); end
      if (wen) model[d][wa] = wv;
   endtask

   task automatic test_reset();
      do_reset(3);
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if ({dout[d], rdv[d], bsy[d], er[d]} !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs d=%0d got=%h/%b/%b/%b exp=0", d, dout[d], rdv[d], bsy[d], er[d]);
         end
      end
      tick();
   endtask

   task automatic test_fill();
      for (int d = 0; d < 3; d++)
         for (int a = 0; a < 32; a++) do_write(d, 5'(a), 8'($urandom));
   endtask

   task automatic test_write_read();
      do_write(0, 5'd3, 8'h5A);
      do_read(0, 5'd3, 1, 1'b0, 5'd0, 8'd0);
   endtask

   task automatic test_long_strobe();
      do_read(0, 5'd7, 6, 1'b0, 5'd0, 8'd0);
   endtask

   task automatic test_write_during_read();
      do_write(0, 5'd4, 8'h11);
      do_read(0, 5'd4, 2, 1'b1, 5'd4, 8'h22);
      do_read(0, 5'd4, 1, 1'b0, 5'd0, 8'd0);
      n_checks++;
      if (model[0][4] !== 8'h22 || dout[0] !== 8'h22) begin
         n_fail++; $display("FAIL flushed_value got=%h exp=22", dout[0]);
      end
   endtask

   task automatic test_err();
      logic [4:0] a, b, c;
      logic [7:0] v1;
      // Simultaneous read and write rise.
      addr = 5'd9; din = ~model[0][9]; mrd[0] = 1'b1; mwr[0] = 1'b1;
      tick();
      exp_err[0] = 1'b1;
      n_checks++;
      if (er[0] !== 1'b1 || bsy[0] !== 1'b0) begin
         n_fail++; $display("FAIL err_simul got=%b/%b exp=1/0", er[0], bsy[0]);
      end
      mrd[0] = 1'b0; mwr[0] = 1'b0;
      tick();
      do_read(0, 5'd9, 1, 1'b0, 5'd0, 8'd0);
      do_reset(1);
      n_checks++;
      if (er[0] !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", er[0]); end
      tick();
      // Second write while the buffer is already occupied.
      a = 5'd12; b = 5'd20; c = 5'd21; v1 = ~model[0][b];
      addr = a; mrd[0] = 1'b1;
      tick();
      mrd[0] = 1'b0; mwr[0] = 1'b1; addr = b; din = v1;
      tick();
      mwr[0] = 1'b0;
      tick();
      mwr[0] = 1'b1; addr = c; din = ~model[0][c];
      tick();
      exp_err[0] = 1'b1;
      n_checks++;
      if (er[0] !== 1'b1 || rdv[0] !== 1'b1 || dout[0] !== model[0][a]) begin
         n_fail++; $display("FAIL err_double_wr got=%b/%b/%h exp=1/1/%h", er[0], rdv[0], dout[0], model[0][a]);
      end
      mwr[0] = 1'b0;
      tick();
      tick();
      model[0][b] = v1;
      do_read(0, c, 1, 1'b0, 5'd0, 8'd0);
      do_read(0, b, 1, 1'b0, 5'd0, 8'd0);
      do_reset(1);
      n_checks++;
      if (er[0] !== 1'b0) begin n_fail++; $display("FAIL err_clear2 got=%b exp=0", er[0]); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      logic [4:0] a, b;
      a = 5'd5; b = 5'd6;
      addr = a; mrd[0] = 1'b1;
      tick();
      mrd[0] = 1'b0; mwr[0] = 1'b1; addr = b; din = ~model[0][b];
      tick();
      mwr[0] = 1'b0; rst = 1'b1;
      for (int i = 0; i < 3; i++) exp_err[i] = 1'b0;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({dout[0], rdv[0], bsy[0], er[0]} !== 11'd0) begin
         n_fail++; $display("FAIL rst_mid_outputs got=%h/%b/%b/%b exp=0", dout[0], rdv[0], bsy[0], er[0]);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (rdv[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid i=%0d got=%b exp=0", i, rdv[0]); end
      end
      do_read(0, b, 1, 1'b0, 5'd0, 8'd0);
      do_read(0, a, 1, 1'b0, 5'd0, 8'd0);
   endtask

   task automatic test_latency_sweep();
      do_write(1, 5'd10, 8'hC3);
      do_read(1, 5'd10, 1, 1'b0, 5'd0, 8'd0);
      do_write(2, 5'd10, 8'h3C);
      do_read(2, 5'd10, 1, 1'b0, 5'd0, 8'd0);
      do_read(2, 5'd11, 3, 1'b1, 5'd11, 8'hE7);
   endtask

   task automatic test_random();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 2) == 0)
               do_write(d, 5'($urandom), 8'($urandom));
            else
               do_read(d, 5'($urandom), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                       5'($urandom), 8'($urandom));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin mrd[i] = 1'b0; mwr[i] = 1'b0; exp_err[i] = 1'b0; end
      test_reset();
      test_fill();
      test_write_read();
      test_long_strobe();
      test_write_during_read();
      test_err();
      test_reset_mid_read();
      test_latency_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
